// File: rtl/reg_bank.sv
// Bank of DEPTH registers on one shared tri-state bus, with two combinational ALU read ports,
// per-register load/inc/dec/clear and a one-cycle wrap pulse.
module reg_bank #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             wr_en,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    wr_addr,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    inout  wire  [WIDTH-1:0] bus,
    input  logic [AW-1:0]    a_addr,
    input  logic [AW-1:0]    b_addr,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic             wrap
);

    typedef enum logic [1:0] {
        OpLoad = 2'b00,
        OpInc  = 2'b01,
        OpDec  = 2'b10,
        OpClr  = 2'b11
    } op_e;

    localparam logic [WIDTH-1:0] AllOnes = '1;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic             wrap_d;
    logic             wrap_q;

    assign cur = regs_q[wr_addr];

    // LOAD samples the bus; on a self-load the bus carries the registered value, so no loop.
    always_comb begin
        nxt    = cur;
        wrap_d = 1'b0;
        unique case (op_e'(op))
            OpLoad: nxt = bus;
            OpInc: begin
                nxt    = cur + WIDTH'(1);
                wrap_d = (cur == AllOnes);
            end
            OpDec: begin
                nxt    = cur - WIDTH'(1);
                wrap_d = (cur == '0);
            end
            OpClr:  nxt = '0;
        endcase
        if (!wr_en) begin
            wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            regs_q <= '{default: '0};
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            if (wr_en) begin
                regs_q[wr_addr] <= nxt;
            end
        end
    end

    assign bus   = rd_en ? regs_q[rd_addr] : {WIDTH{1'bz}};
    assign reg_a = regs_q[a_addr];
    assign reg_b = regs_q[b_addr];
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench: an 8x4 and a 16x8 bank share one stimulus stream; a per-cycle expectation
// queue is filled from an array model and drained by an independent negedge monitor.
module tb_reg_bank;

    localparam logic [1:0] LD  = 2'd0;
    localparam logic [1:0] INC = 2'd1;
    localparam logic [1:0] DEC = 2'd2;
    localparam logic [1:0] CLR = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr_n, wr_en, rd_en, drv_oe;
    logic [1:0]  op;
    logic [2:0]  wr_addr, rd_addr, a_addr, b_addr;
    logic [15:0] drv_val;

    wire  [7:0]  bus_s;
    wire  [15:0] bus_l;
    logic [7:0]  reg_a_s, reg_b_s;
    logic [15:0] reg_a_l, reg_b_l;
    logic        wrap_s, wrap_l;

    assign bus_s = drv_oe ? drv_val[7:0] : 8'hzz;
    assign bus_l = drv_oe ? drv_val : 16'hzzzz;

    reg_bank #(.WIDTH(8), .DEPTH(4), .AW(2)) u_small (
        .clk(clk), .clr_n(clr_n), .wr_en(wr_en), .op(op), .wr_addr(wr_addr[1:0]),
        .rd_en(rd_en), .rd_addr(rd_addr[1:0]), .bus(bus_s), .a_addr(a_addr[1:0]),
        .b_addr(b_addr[1:0]), .reg_a(reg_a_s), .reg_b(reg_b_s), .wrap(wrap_s)
    );

    reg_bank #(.WIDTH(16), .DEPTH(8), .AW(3)) u_large (
        .clk(clk), .clr_n(clr_n), .wr_en(wr_en), .op(op), .wr_addr(wr_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .bus(bus_l), .a_addr(a_addr),
        .b_addr(b_addr), .reg_a(reg_a_l), .reg_b(reg_b_l), .wrap(wrap_l)
    );

    typedef struct packed {
        logic [1:0][15:0] ra;
        logic [1:0][15:0] rb;
        logic [1:0][15:0] bv;
        logic             bchk;
        logic [1:0]       w;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m [2][8];
    logic        wm [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [15:0] dmask(input int c);
        return (c == 0) ? 16'h00FF : 16'hFFFF;
    endfunction

    function automatic int amask(input int c);
        return (c == 0) ? 3 : 7;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // One clock of stimulus: drive, record what the outputs must show this cycle, advance model.
    task automatic step(input bit rst, input bit wr, input logic [1:0] o, input logic [2:0] wa,
                        input bit rd, input logic [2:0] ra, input logic [2:0] aa,
                        input logic [2:0] ba, input bit oe, input logic [15:0] dv);
        exp_t e;
        @(posedge clk);
        #1;
        clr_n = !rst; wr_en = wr; op = o; wr_addr = wa; rd_en = rd; rd_addr = ra;
        a_addr = aa; b_addr = ba; drv_oe = oe; drv_val = dv;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 8; i++) m[c][i] = '0;
                wm[c] = 1'b0;
            end
        end
        e = '0;
        e.bchk = rd | oe;
        for (int c = 0; c < 2; c++) begin
            logic [15:0] msk;
            logic [15:0] busv;
            logic [15:0] cur;
            int          iw;
            msk  = dmask(c);
            iw   = int'(wa) & amask(c);
            busv = rd ? m[c][int'(ra) & amask(c)] : (dv & msk);
            e.ra[c] = m[c][int'(aa) & amask(c)];
            e.rb[c] = m[c][int'(ba) & amask(c)];
            e.bv[c] = busv;
            e.w[c]  = wm[c];
            if (!rst) begin
                cur   = m[c][iw];
                wm[c] = 1'b0;
                if (wr) begin
                    case (o)
                        LD:  m[c][iw] = busv;
                        INC: begin
                            m[c][iw] = (cur + 16'd1) & msk;
                            wm[c]    = (cur == msk);
                        end
                        DEC: begin
                            m[c][iw] = (cur - 16'd1) & msk;
                            wm[c]    = (cur == 16'd0);
                        end
                        default: m[c][iw] = '0;
                    endcase
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [2:0] wa, input logic [15:0] v);
        step(1'b0, 1'b1, LD, wa, 1'b0, 3'd0, wa, wa, 1'b1, v);
    endtask

    task automatic opr(input logic [1:0] o, input logic [2:0] wa);
        step(1'b0, 1'b1, o, wa, 1'b0, 3'd0, wa, wa, 1'b0, 16'd0);
    endtask

    task automatic look(input logic [2:0] aa, input logic [2:0] ba, input bit rd,
                        input logic [2:0] ra);
        step(1'b0, 1'b0, LD, 3'd0, rd, ra, aa, ba, 1'b0, 16'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("reg_a_s", {8'h00, reg_a_s}, e.ra[0]);
            check("reg_b_s", {8'h00, reg_b_s}, e.rb[0]);
            check("reg_a_l", reg_a_l, e.ra[1]);
            check("reg_b_l", reg_b_l, e.rb[1]);
            check("wrap_s", {15'd0, wrap_s}, {15'd0, e.w[0]});
            check("wrap_l", {15'd0, wrap_l}, {15'd0, e.w[1]});
            if (e.bchk) begin
                check("bus_s", {8'h00, bus_s}, e.bv[0]);
                check("bus_l", bus_l, e.bv[1]);
            end
        end
    end

    initial begin
        clr_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; drv_oe = 1'b0; op = LD;
        wr_addr = '0; rd_addr = '0; a_addr = '0; b_addr = '0; drv_val = '0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 8; i++) m[c][i] = '0;
            wm[c] = 1'b0;
        end

        look(3'd0, 3'd1, 1'b0, 3'd0);
        load(3'd0, 16'h005A);
        look(3'd0, 3'd1, 1'b1, 3'd0);
        // Arm a wrap pulse, then reset mid-operation with a write pending.
        load(3'd1, 16'hFFFF);
        opr(INC, 3'd1);
        step(1'b1, 1'b1, INC, 3'd0, 1'b0, 3'd0, 3'd0, 3'd1, 1'b0, 16'd0);
        look(3'd0, 3'd2, 1'b0, 3'd0);

        load(3'd2, 16'h00C3);
        look(3'd2, 3'd0, 1'b1, 3'd2);
        step(1'b0, 1'b0, LD, 3'd0, 1'b0, 3'd0, 3'd2, 3'd2, 1'b1, 16'h1234);

        load(3'd1, 16'h0011);
        load(3'd3, 16'h0077);
        step(1'b0, 1'b1, LD, 3'd1, 1'b1, 3'd3, 3'd1, 3'd3, 1'b0, 16'd0);
        look(3'd1, 3'd3, 1'b0, 3'd0);
        step(1'b0, 1'b1, LD, 3'd3, 1'b1, 3'd3, 3'd3, 3'd1, 1'b0, 16'd0);
        look(3'd3, 3'd1, 1'b1, 3'd3);

        load(3'd0, 16'hFFFF);
        opr(INC, 3'd0);
        look(3'd0, 3'd1, 1'b0, 3'd0);
        look(3'd0, 3'd1, 1'b0, 3'd0);
        opr(DEC, 3'd0);
        look(3'd0, 3'd1, 1'b1, 3'd0);
        load(3'd0, 16'h007F);
        opr(INC, 3'd0);
        look(3'd0, 3'd1, 1'b0, 3'd0);
        load(3'd5, 16'h00FF);
        opr(INC, 3'd5);
        look(3'd5, 3'd1, 1'b1, 3'd5);

        load(3'd1, 16'h0102);
        look(3'd1, 3'd3, 1'b0, 3'd0);
        opr(CLR, 3'd1);
        look(3'd1, 3'd3, 1'b0, 3'd0);

        for (int i = 0; i < 8; i++) load(3'(i), 16'(i * 16'h1111 + 1));
        for (int i = 0; i < 8; i++) look(3'(i), 3'(7 - i), 1'b1, 3'(i));

        for (int n = 0; n < 500; n++) begin
            bit          rst, wr, rd, oe;
            logic [1:0]  o;
            logic [15:0] dv;
            rst = ($urandom_range(0, 49) == 0);
            wr  = ($urandom_range(0, 3) != 0);
            rd  = $urandom_range(0, 1) == 1;
            o   = 2'($urandom_range(0, 3));
            oe  = !rd && (($urandom_range(0, 1) == 1) || (wr && o == LD));
            case ($urandom_range(0, 3))
                0:       dv = 16'h0000;
                1:       dv = 16'hFFFF;
                2:       dv = 16'h00FF;
                default: dv = 16'($urandom);
            endcase
            step(rst, wr, o, 3'($urandom_range(0, 7)), rd, 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), oe, dv);
        end

        @(posedge clk);
        #1;
        wr_en = 1'b0; drv_oe = 1'b0; rd_en = 1'b0; clr_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised multi-register bank; next generation of the single 8-bit bus register.
- Holds DEPTH registers of WIDTH bits. All registers share one bidirectional tri-state system bus.
- Two independent read ports feed the ALU.
- Adds per-cycle register operations (load, increment, decrement, clear), one-cycle register-to-register transfer, and a registered wrap flag.

Parameters:
- WIDTH, 8, register and bus width in bits (>=2)
- DEPTH, 4, number of registers (power of two, >=2)
- AW, 2, address width; must equal log2(DEPTH)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- clr_n  input  1  asynchronous active-low reset; clears every register and flag
- wr_en  input  1  active high; perform op on register wr_addr at the next rising edge
- op  input  2  operation: 00 LOAD from bus, 01 INC, 10 DEC, 11 CLR
- wr_addr  input  AW  target register of op
- rd_en  input  1  active high; drive register rd_addr onto bus
- rd_addr  input  AW  register driven onto bus
- bus  inout  WIDTH  shared system bus; high-impedance when rd_en=0
- a_addr  input  AW  ALU port A select
- b_addr  input  AW  ALU port B select
- reg_a  output  WIDTH  contents of register a_addr (combinational read of current state)
- reg_b  output  WIDTH  contents of register b_addr (combinational read of current state)
- wrap  output  1  registered; 1 for one cycle after an INC or DEC that wrapped

Behaviour:
- Reset (clr_n=0, asynchronous, any time, including mid-operation):
  - All registers become 0; wrap=0.
  - reg_a and reg_b read 0 immediately.
  - bus follows rd_en; a driven register reads 0.
  - Reset dominates wr_en.
- Bus drive is combinational:
  - rd_en=1: bus = reg[rd_addr].
  - rd_en=0: bus = all Z.
  - No registered latency on the read paths (bus, reg_a, reg_b).
- Write timing: wr_en=1 at a rising edge updates reg[wr_addr]. The new value is visible on reg_a, reg_b and bus in the following cycle. wr_en=0 holds all registers.
- LOAD: reg[wr_addr] <= value on bus at the edge. Bus Z or X with rd_en=0 is the external driver's responsibility; the block samples whatever is present.
- INC: reg <= reg+1 modulo 2^WIDTH. DEC: reg <= reg-1 modulo 2^WIDTH. The bus is not used.
- CLR: reg <= 0. The bus is not used.
- wrap:
  - Set to 1 at the edge where INC takes all-ones to 0, or DEC takes 0 to all-ones.
  - Otherwise set to 0 at every edge, including cycles with wr_en=0.
  - Each wrap is therefore a one-cycle pulse.
- Register-to-register move: rd_en=1, wr_en=1, op=LOAD, rd_addr != wr_addr gives reg[wr_addr] <= reg[rd_addr] in one cycle. The bus carries the source value.
- Self-load: rd_en=1, wr_en=1, op=LOAD, rd_addr == wr_addr leaves the register unchanged. This is legal and free of combinational loops, because the load samples the registered value.
- Non-LOAD op with rd_en=1: the bus shows the pre-edge value of reg[rd_addr]. If rd_addr == wr_addr, the new value appears on the bus the next cycle.
- Only one register is written per edge; no other register changes.
- Addresses are always in range (AW = log2(DEPTH)); there is no out-of-range case.
- External bus contention (rd_en=1 while another driver is active) is a system-level error and is not detected here.

Test Plan:
- Reset: preload reg0=0x5A, then pulse clr_n low between clock edges → all registers read 0x00 on reg_a/reg_b immediately; wrap=0; bus=Z with rd_en=0.
- Load and tri-state: bench drives bus=0xC3, wr_en=1, op=LOAD, wr_addr=2; then releases the bus and sets rd_en=1, rd_addr=2 → bus=0xC3. With rd_en=0 → bus=ZZ. reg_a with a_addr=2 reads 0xC3.
- Move: reg1=0x11, reg3=0x77; rd_en=1, rd_addr=3, wr_en=1, op=LOAD, wr_addr=1 → next cycle reg1=0x77, reg3 unchanged. Self-load on reg3 → stays 0x77.
- Wrap:
  - reg0=0xFF, INC → reg0=0x00 and wrap=1 for exactly one cycle.
  - DEC on 0x00 → 0xFF, wrap=1.
  - INC on 0x7F → 0x80, wrap=0.
- Dual read / isolation: a_addr=1, b_addr=3 read distinct values simultaneously. CLR on reg1 → reg_a=0x00 next cycle; reg_b and all other registers unchanged.
- Parameter sweep: WIDTH=16, DEPTH=8, AW=3; repeat the load, move and wrap scenarios → wrap at 0xFFFF→0x0000; all 8 registers addressable and independent.
